vga_timing_gen: RTL
===================

# vga_timing_gen

Parametrised VGA timing generator replacing the fixed 640x400 sync block. Produces registered hsync/vsync, active-video flag, pixel coordinates, and line/frame strobes. Drives NUM_WIN independent rectangular overlay windows, each with its own glyph-row index. Window bounds are runtime-programmable and tear-free: new values take effect only at frame boundaries. Sits between the 25 MHz clock domain root and the pixel/character renderer.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal porches and sync, in pixels
- V_ACTIVE, 400, visible lines
- V_FP, 12; V_SYNC, 2; V_BP, 35: vertical porches and sync, in lines
- HS_POL, 0, active level of hsync
- VS_POL, 1, active level of vsync
- NUM_WIN, 2, number of overlay windows (1..8)
- ROW_W, 4, width of each window row index
- Reset: reset, asynchronous, active-high. Clock: clk25.
- clk25  in  1  pixel clock
- reset  in  1  async active-high reset
- cfg_we  in  1  write strobe for a window shadow register
- cfg_sel  in  3  target window index; writes with cfg_sel >= NUM_WIN are ignored
- cfg_en  in  1  window enable
- cfg_left, cfg_right  in  10  inclusive horizontal bounds, in active-pixel coordinates
- cfg_top, cfg_bottom  in  10  inclusive vertical bounds, in active-line coordinates
- cfg_pending  out  1  shadow written, not yet committed
- hsync, vsync  out  1  sync outputs at configured polarity
- active  out  1  inside the visible region
- x, y  out  10  pixel/line coordinate; 0 outside the active region
- line_start  out  1  one-cycle pulse at h=0 of every line
- frame_start  out  1  one-cycle pulse at h=0, v=0
- win_hit  out  NUM_WIN  per-window inside flag
- win_row  out  ROW_W*NUM_WIN  per-window row index; window k occupies bits [k*ROW_W +: ROW_W]

## Operation
- Counters and totals:
  - H_TOTAL = sum of the H parameters (800). h counts 0..H_TOTAL-1 and wraps to 0.
  - V_TOTAL = sum of the V parameters (449). v increments when h wraps, counts 0..V_TOTAL-1, and wraps.
  - Both counters are 10 bits. Elaboration fails if either total exceeds 1024.
- Region order on each axis: active, front porch, sync, back porch.
  - h_sync is asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC. Vertical follows the same rule.
- active = (h < H_ACTIVE) && (v < V_ACTIVE).
  - When active: x = h, y = v. Otherwise x = y = 0.
- Window k:
  - hit = en && left <= h <= right && top <= v <= bottom && active.
  - left > right or top > bottom produces no hit.
  - row = (v - top) truncated to ROW_W bits when hit, else 0.
- Shadow/commit handshake:
  - cfg_we loads the shadow bounds of window cfg_sel and sets cfg_pending.
  - Commit happens at h = H_TOTAL-1, v = V_TOTAL-1: all shadows copy to the live bounds together and cfg_pending clears.
  - A write in the commit cycle is not part of that commit. It stays in the shadow, cfg_pending stays 1, and it commits at the next frame end.
  - Back-to-back writes to the same window: the last one wins.

## Timing
- Every output is registered. Outputs for counter state (h,v) appear exactly 1 cycle after the counters hold (h,v). All outputs are mutually aligned.
- Reset values:
  - h = v = 0.
  - hsync = ~HS_POL, vsync = ~VS_POL.
  - active, x, y, line_start, frame_start, win_hit, win_row, cfg_pending all 0.
  - Live and shadow bounds all 0, and every window disabled.
- First rising clk25 edge after reset releases: outputs reflect (0,0), so frame_start = 1, line_start = 1, active = 1.
- Reset asserted mid-frame: all outputs return to their reset values immediately, asynchronously. Pending writes are discarded.
- Frame period = H_TOTAL*V_TOTAL = 359200 cycles.

## Structure
- Package vga_pkg holds:
  - default timing constants;
  - a window_t struct (en, left, right, top, bottom);
  - a function that computes a total from its four timing parameters.
- Sub-module vga_window, instantiated NUM_WIN times via generate:
  - holds the shadow and live registers plus the compare/row logic for one window;
  - inputs: h, v, active, commit, write strobe, cfg fields;
  - outputs: pre-register hit and row.

## Test plan
- Default parameters, run 2 frames:
  - hsync low for h = 656..751 and vsync high for v = 412..413;
  - frame_start spacing exactly 359200 cycles; line_start spacing 800 cycles.
- Program window 0 = (475, 482, 241, 256), enabled, mid-frame:
  - no hit before the next frame_start, and cfg_pending = 1 until then;
  - afterwards win_hit[0] = 1 only for x in 475..482 and y in 241..256;
  - win_row goes 0..15, and wraps to 0 at y = 257 boundary? No: hit drops at y = 257.
- cfg_we issued in the commit cycle: the value appears one frame later than a write made 1 cycle earlier.
- Two overlapping windows (0 and 1) plus cfg_sel = 5 with NUM_WIN = 2:
  - both hits assert independently;
  - the cfg_sel = 5 write has no effect and does not set cfg_pending.
- Assert reset at h = 300, v = 100 for 3 cycles:
  - outputs go to their reset values asynchronously and windows are disabled;
  - the restart produces frame_start on the first edge after release.
- Re-parametrise to 800x600 (H 800/40/128/88, V 600/1/4/23, HS_POL = VS_POL = 1):
  - line period 1056 is rejected at elaboration;
  - 640x480 (800/525 totals) gives a 420000-cycle frame period.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing defaults, window record and total helper
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 400;
    localparam int V_FP_DEF     = 12;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 35;
    localparam int CNT_W        = 10;
    localparam int CNT_LIMIT    = 1 << CNT_W;

    typedef struct packed {
        logic             en;
        logic [CNT_W-1:0] left;
        logic [CNT_W-1:0] right;
        logic [CNT_W-1:0] top;
        logic [CNT_W-1:0] bottom;
    } window_t;

    function automatic int timing_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - window configuration bus between host and timing generator
interface vga_timing_gen_if;

    logic       cfg_we;
    logic [2:0] cfg_sel;
    logic       cfg_en;
    logic [9:0] cfg_left;
    logic [9:0] cfg_right;
    logic [9:0] cfg_top;
    logic [9:0] cfg_bottom;
    logic       cfg_pending;

    modport master (
        output cfg_we, cfg_sel, cfg_en, cfg_left, cfg_right, cfg_top, cfg_bottom,
        input  cfg_pending
    );

    modport slave (
        input  cfg_we, cfg_sel, cfg_en, cfg_left, cfg_right, cfg_top, cfg_bottom,
        output cfg_pending
    );

endinterface

// File: rtl/vga_window.sv
// rtl/vga_window.sv - one overlay window: shadow/live bounds and unregistered hit/row compare
module vga_window
    import vga_pkg::*;
#(
    parameter int ROW_W = 4
) (
    input  logic             clk25,
    input  logic             reset,
    input  logic [CNT_W-1:0] h,
    input  logic [CNT_W-1:0] v,
    input  logic             active,
    input  logic             commit,
    input  logic             we,
    input  logic             cfg_en,
    input  logic [CNT_W-1:0] cfg_left,
    input  logic [CNT_W-1:0] cfg_right,
    input  logic [CNT_W-1:0] cfg_top,
    input  logic [CNT_W-1:0] cfg_bottom,
    output logic             hit,
    output logic [ROW_W-1:0] row
);

    window_t shadow_q, shadow_d;
    window_t live_q, live_d;

    // A write landing on the commit edge stays in the shadow; live takes the previous shadow.
    always_comb begin
        shadow_d = shadow_q;
        live_d   = live_q;
        if (we) begin
            shadow_d = '{en: cfg_en, left: cfg_left, right: cfg_right,
                         top: cfg_top, bottom: cfg_bottom};
        end
        if (commit) begin
            live_d = shadow_q;
        end
    end

    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            shadow_q <= '0;
            live_q   <= '0;
        end else begin
            shadow_q <= shadow_d;
            live_q   <= live_d;
        end
    end

    always_comb begin
        hit = live_q.en && active
            && (h >= live_q.left) && (h <= live_q.right)
            && (v >= live_q.top)  && (v <= live_q.bottom);
        row = hit ? ROW_W'(v - live_q.top) : '0;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA sync/coordinate generator with tear-free overlay windows
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b1,
    parameter int NUM_WIN  = 2,
    parameter int ROW_W    = 4
) (
    input  logic                     clk25,
    input  logic                     reset,
    vga_timing_gen_if.slave          cfg,
    output logic                     hsync,
    output logic                     vsync,
    output logic                     active,
    output logic [CNT_W-1:0]         x,
    output logic [CNT_W-1:0]         y,
    output logic                     line_start,
    output logic                     frame_start,
    output logic [NUM_WIN-1:0]       win_hit,
    output logic [ROW_W*NUM_WIN-1:0] win_row
);

    localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > CNT_LIMIT || V_TOTAL > CNT_LIMIT) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL %0d / V_TOTAL %0d exceed 10-bit counters", H_TOTAL, V_TOTAL);
    end
    if (NUM_WIN < 1 || NUM_WIN > 8) begin : g_bad_num_win
        $error("vga_timing_gen: NUM_WIN %0d outside 1..8", NUM_WIN);
    end

    // One extra bit so region ends equal to 1024 still compare correctly.
    localparam logic [CNT_W:0]   HA_END   = (CNT_W+1)'(H_ACTIVE);
    localparam logic [CNT_W:0]   HS_START = (CNT_W+1)'(H_ACTIVE + H_FP);
    localparam logic [CNT_W:0]   HS_STOP  = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W:0]   VA_END   = (CNT_W+1)'(V_ACTIVE);
    localparam logic [CNT_W:0]   VS_START = (CNT_W+1)'(V_ACTIVE + V_FP);
    localparam logic [CNT_W:0]   VS_STOP  = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    logic             pend_q, pend_d, pend_out_q, pend_out_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d;
    logic             active_q, active_d;
    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    logic             line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic [NUM_WIN-1:0]       win_hit_q, win_hit_d;
    logic [ROW_W*NUM_WIN-1:0] win_row_q, win_row_d;
    logic             commit, wr_ok, h_end, v_end, hs_on, vs_on;

    always_comb begin
        h_end  = (h_q == H_LAST);
        v_end  = (v_q == V_LAST);
        commit = h_end && v_end;
        h_d    = h_end ? '0 : h_q + 1'b1;
        v_d    = v_q;
        if (h_end) begin
            v_d = v_end ? '0 : v_q + 1'b1;
        end

        hs_on    = ({1'b0, h_q} >= HS_START) && ({1'b0, h_q} < HS_STOP);
        vs_on    = ({1'b0, v_q} >= VS_START) && ({1'b0, v_q} < VS_STOP);
        hsync_d  = hs_on ? HS_POL : ~HS_POL;
        vsync_d  = vs_on ? VS_POL : ~VS_POL;
        active_d = ({1'b0, h_q} < HA_END) && ({1'b0, v_q} < VA_END);
        x_d      = active_d ? h_q : '0;
        y_d      = active_d ? v_q : '0;
        line_start_d  = (h_q == '0);
        frame_start_d = (h_q == '0) && (v_q == '0);

        // Pending flag is delayed one stage so it drops together with frame_start.
        wr_ok  = cfg.cfg_we && ({1'b0, cfg.cfg_sel} < 4'(NUM_WIN));
        pend_d = commit ? 1'b0 : pend_q;
        if (wr_ok) begin
            pend_d = 1'b1;
        end
        pend_out_d = pend_q;
    end

    for (genvar k = 0; k < NUM_WIN; k++) begin : g_win
        vga_window #(.ROW_W(ROW_W)) u_win (
            .clk25      (clk25),
            .reset      (reset),
            .h          (h_q),
            .v          (v_q),
            .active     (active_d),
            .commit     (commit),
            .we         (wr_ok && (cfg.cfg_sel == 3'(k))),
            .cfg_en     (cfg.cfg_en),
            .cfg_left   (cfg.cfg_left),
            .cfg_right  (cfg.cfg_right),
            .cfg_top    (cfg.cfg_top),
            .cfg_bottom (cfg.cfg_bottom),
            .hit        (win_hit_d[k]),
            .row        (win_row_d[k*ROW_W +: ROW_W])
        );
    end

    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            h_q           <= '0;
            v_q           <= '0;
            pend_q        <= 1'b0;
            pend_out_q    <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            active_q      <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            win_hit_q     <= '0;
            win_row_q     <= '0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            pend_q        <= pend_d;
            pend_out_q    <= pend_out_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            win_hit_q     <= win_hit_d;
            win_row_q     <= win_row_d;
        end
    end

    assign hsync           = hsync_q;
    assign vsync           = vsync_q;
    assign active          = active_q;
    assign x               = x_q;
    assign y               = y_q;
    assign line_start      = line_start_q;
    assign frame_start     = frame_start_q;
    assign win_hit         = win_hit_q;
    assign win_row         = win_row_q;
    assign cfg.cfg_pending = pend_out_q;

endmodule
